// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: RAM self-test sequencer started after PLL lock.
// Loops write-all / read-all / compare passes with a rolling seed.
module ram_bist_ctrl #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int LOCK_WAIT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          locked,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    output logic [7:0]    led_o
);

    localparam int LCW = $clog2(LOCK_WAIT + 1);
    localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_WAIT - 1);
    localparam logic [1:0]     DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [AW-1:0]  ADDR_LAST  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LCW-1:0]    r_lcnt;
    logic [LCW-1:0]    w_lcnt_nxt;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     w_addr_nxt;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     w_wdata_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_re;
    logic              w_re_nxt;
    logic [DW-1:0]     r_seed;
    logic [DW-1:0]     w_seed_nxt;
    logic [3:0]        r_pcnt;
    logic [3:0]        w_pcnt_nxt;
    logic              r_pass;
    logic              w_pass_nxt;
    logic              r_fail;
    logic              w_fail_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [1:0]        r_dcnt;
    logic [1:0]        w_dcnt_nxt;
    logic [7:0]        r_led;
    logic [7:0]        w_led_nxt;
    logic              w_busy_nxt;
    logic [RD_LAT-1:0] r_pv;
    logic [DW-1:0]     r_pexp [RD_LAT];
    logic              w_abort;
    logic              w_cmp_bad;

    // Test pattern: address (resized to DW) XOR the pass seed
    function automatic logic [DW-1:0] f_pat(
        input logic [AW-1:0] a,
        input logic [DW-1:0] s
    );
        return DW'(a) ^ s;
    endfunction

    // Losing lock anywhere outside IDLE abandons the pass
    assign w_abort = (r_state != S_IDLE) && !locked;

    // Only pipeline slots that carry a real read are compared
    assign w_cmp_bad = ((r_state == S_READ) || (r_state == S_DRAIN))
                     && r_pv[RD_LAT-1]
                     && (ram_rdata != r_pexp[RD_LAT-1]);

    // Next-state, next-output and pass bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        w_addr_nxt  = r_addr;
        w_we_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_seed_nxt  = r_seed;
        w_pcnt_nxt  = r_pcnt;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_err_nxt   = r_err;
        w_dcnt_nxt  = r_dcnt;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_lcnt_nxt  = '0;
            w_addr_nxt  = '0;
            w_err_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!locked) begin
                        w_lcnt_nxt = '0;
                    end else if (r_lcnt == LOCK_LAST) begin
                        w_state_nxt = S_SETTLE;
                        w_lcnt_nxt  = '0;
                    end else begin
                        w_lcnt_nxt = r_lcnt + LCW'(1);
                    end
                end
                S_SETTLE: begin
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    if (r_addr == ADDR_LAST) begin
                        w_addr_nxt  = '0;
                        w_re_nxt    = 1'b1;
                        w_state_nxt = S_READ;
                    end else begin
                        w_addr_nxt = r_addr + AW'(1);
                        w_we_nxt   = 1'b1;
                    end
                end
                S_READ: begin
                    w_err_nxt = r_err | w_cmp_bad;
                    if (r_addr == ADDR_LAST) begin
                        w_addr_nxt  = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_addr_nxt = r_addr + AW'(1);
                        w_re_nxt   = 1'b1;
                    end
                end
                S_DRAIN: begin
                    w_err_nxt = r_err | w_cmp_bad;
                    if (r_dcnt == DRAIN_LAST) begin
                        w_state_nxt = S_REPORT;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 2'd1;
                    end
                end
                S_REPORT: begin
                    if (!r_err) begin
                        w_pass_nxt = 1'b1;
                        w_pcnt_nxt = r_pcnt + 4'd1;
                    end else begin
                        w_fail_nxt = 1'b1;
                    end
                    w_seed_nxt  = r_seed + DW'(1);
                    w_err_nxt   = 1'b0;
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
        w_wdata_nxt = w_we_nxt ? f_pat(w_addr_nxt, w_seed_nxt) : '0;
        w_busy_nxt  = (w_state_nxt == S_WRITE)
                    || (w_state_nxt == S_READ)
                    || (w_state_nxt == S_DRAIN);
        w_led_nxt   = {w_pcnt_nxt, w_fail_nxt, w_pass_nxt,
                       w_busy_nxt, (w_state_nxt != S_IDLE)};
    end

    // State and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lcnt  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_seed  <= '0;
            r_pcnt  <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_err   <= 1'b0;
            r_dcnt  <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_re    <= w_re_nxt;
            r_seed  <= w_seed_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_err   <= w_err_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_led   <= w_led_nxt;
        end
    end

    // Expected-data pipeline lined up with ram_rdata RD_LAT cycles later
    always_ff @(posedge clk) begin
        r_pexp[0] <= f_pat(r_addr, r_seed);
        for (int i = 1; i < RD_LAT; i++) begin
            r_pexp[i] <= r_pexp[i-1];
        end
        if (rst || w_abort) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= (r_state == S_READ);
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_we    = r_we;
    assign ram_re    = r_re;
    assign led_o     = r_led;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: two BIST instances (read latency 1 and 3) on
// behavioural RAMs, checked every cycle against a pass-position model.
module tb_ram_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 16;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          rst;
    logic          locked;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          we0, we1, re0, re1;
    logic [DW-1:0] rdata0, rdata1;
    logic [7:0]    led0, led1;

    int n_cmp;
    int n_bad;

    // reference model: position within the current pass
    bit  m_idle [2];
    int  m_lcnt [2];
    int  m_pos  [2];
    int  m_seed [2];
    int  m_pcnt [2];
    bit  m_pass [2];
    bit  m_fail [2];
    bit  m_bad  [2];
    bit  m_rst;

    // behavioural RAMs and fault injection
    logic [DW-1:0] mem [2][N];
    logic [DW-1:0] rp  [2][3];
    int  c_addr [2];
    int  c_seed [2];
    bit  rnd_bad;

    ram_bist_ctrl #(
        .AW(AW), .DW(DW), .RD_LAT(1), .LOCK_WAIT(LW)
    ) u_dut0 (
        .clk(clk), .rst(rst), .locked(locked),
        .ram_addr(addr0), .ram_wdata(wdata0),
        .ram_we(we0), .ram_re(re0),
        .ram_rdata(rdata0), .led_o(led0)
    );

    ram_bist_ctrl #(
        .AW(AW), .DW(DW), .RD_LAT(3), .LOCK_WAIT(LW)
    ) u_dut1 (
        .clk(clk), .rst(rst), .locked(locked),
        .ram_addr(addr1), .ram_wdata(wdata1),
        .ram_we(we1), .ram_re(re1),
        .ram_rdata(rdata1), .led_o(led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step(input int i, input bit r, input bit lk);
        int rep;
        rep = 2 * N + lat_of(i);
        if (r) begin
            m_idle[i] = 1; m_lcnt[i] = 0; m_pos[i] = 0;
            m_seed[i] = 0; m_pcnt[i] = 0;
            m_pass[i] = 0; m_fail[i] = 0; m_bad[i] = 0;
        end else if (m_idle[i]) begin
            if (!lk) m_lcnt[i] = 0;
            else if (m_lcnt[i] == LW - 1) begin
                m_idle[i] = 0; m_pos[i] = -1; m_lcnt[i] = 0;
            end else m_lcnt[i]++;
        end else if (!lk) begin
            m_idle[i] = 1; m_lcnt[i] = 0; m_bad[i] = 0;
        end else if (m_pos[i] == rep) begin
            if (!m_bad[i]) begin
                m_pass[i] = 1;
                m_pcnt[i] = (m_pcnt[i] + 1) % 16;
            end else m_fail[i] = 1;
            m_seed[i] = (m_seed[i] + 1) % 256;
            m_bad[i]  = 0;
            m_pos[i]  = 0;
        end else m_pos[i]++;
    endtask

    task automatic compare(input int i, input logic we, input logic re,
                           input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd,
                           input logic [7:0] led);
        bit ew, er, eb;
        int p;
        p  = m_pos[i];
        ew = !m_idle[i] && p >= 0 && p < N;
        er = !m_idle[i] && p >= N && p < 2 * N;
        eb = !m_idle[i] && p >= 0 && p < 2 * N + lat_of(i);
        chk($sformatf("i%0d_we", i), we, ew);
        chk($sformatf("i%0d_re", i), re, er);
        chk($sformatf("i%0d_excl", i), we & re, 0);
        chk($sformatf("i%0d_led", i), led,
            {4'(m_pcnt[i]), m_fail[i], m_pass[i], eb, !m_idle[i]});
        if (ew) begin
            chk($sformatf("i%0d_waddr", i), ad, p);
            chk($sformatf("i%0d_wdata", i), wd, (p ^ m_seed[i]) & 8'hff);
        end
        if (er) chk($sformatf("i%0d_raddr", i), ad, p - N);
        if (m_rst) begin
            chk($sformatf("i%0d_rst_addr", i), ad, 0);
            chk($sformatf("i%0d_rst_wdata", i), wd, 0);
        end
    endtask

    task automatic tick();
        logic          c_we [2];
        logic          c_re [2];
        logic [AW-1:0] c_ad [2];
        logic [DW-1:0] c_wd [2];
        logic [DW-1:0] v;
        logic [DW-1:0] mask;
        bit c_rst, c_lk, hit;
        c_rst = rst; c_lk = locked;
        c_we[0] = we0; c_re[0] = re0; c_ad[0] = addr0; c_wd[0] = wdata0;
        c_we[1] = we1; c_re[1] = re1; c_ad[1] = addr1; c_wd[1] = wdata1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 2; k > 0; k--) rp[i][k] = rp[i][k-1];
            if (c_we[i] === 1'b1) mem[i][c_ad[i]] = c_wd[i];
            if (c_re[i] === 1'b1) begin
                v    = mem[i][c_ad[i]];
                hit  = int'(c_ad[i]) == c_addr[i] && m_seed[i] == c_seed[i];
                mask = 8'h01;
                if (!hit && rnd_bad && $urandom_range(0, 39) == 0) begin
                    hit  = 1;
                    mask = 8'h01 << $urandom_range(0, 7);
                end
                if (hit) begin
                    v = v ^ mask;
                    m_bad[i] = 1;
                end
                rp[i][0] = v;
            end else rp[i][0] = DW'($urandom);
            model_step(i, c_rst, c_lk);
        end
        m_rst  = c_rst;
        rdata0 = rp[0][0];
        rdata1 = rp[1][2];
        compare(0, we0, re0, addr0, wdata0, led0);
        compare(1, we1, re1, addr1, wdata1, led1);
    endtask

    task automatic reset_dut();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        int n;
        int dn;
        n_cmp = 0; n_bad = 0;
        rst = 1; locked = 0; rnd_bad = 0; m_rst = 0;
        rdata0 = '0; rdata1 = '0;
        c_addr[0] = -1; c_addr[1] = -1;
        c_seed[0] = 0;  c_seed[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) rp[i][k] = '0;

        // lock-wait latency, first pass, second seed
        reset_dut();
        chk("rst_led", led0, 8'h00);
        locked = 1;
        n = 0;
        while (!we0 && n < 40) begin tick(); n++; end
        chk("t1_first_we_edge", n, 17);
        n = 0;
        while (!led0[2] && n < 100) begin tick(); n++; end
        chk("t1_first_report_led", led0, 8'h17);
        chk("t1_pass2_addr", addr0, 0);
        chk("t1_pass2_wdata", wdata0, 8'h01);

        // lock glitch restarts the lock counter
        reset_dut();
        locked = 1;
        repeat (10) begin tick(); chk("t2_lockok", led0[0], 0); end
        locked = 0;
        tick();
        chk("t2_lockok_glitch", led0[0], 0);
        locked = 1;
        n = 0;
        while (!we0 && n < 40) begin
            tick(); n++;
            if (n < 16) chk("t2_lockok_wait", led0[0], 0);
        end
        chk("t2_relock_we_edge", n, 17);

        // corrupt addr 5 (lat 1) and addr 15 (lat 3) on pass 0
        reset_dut();
        c_addr[0] = 5;  c_seed[0] = 0;
        c_addr[1] = 15; c_seed[1] = 0;
        locked = 1;
        n = 0;
        while (!led0[3] && n < 100) begin tick(); n++; end
        chk("t3_fail_pass0", led0[7:2], 6'b0000_10);
        n = 0;
        while (!led0[2] && n < 60) begin tick(); n++; end
        chk("t3_pass1_cnt", led0[7:4], 1);
        chk("t3_fail_kept", led0[3], 1);
        chk("t4_drain_fail", led1[7:2], 6'b0000_10);
        n = 0;
        while (!led1[2] && n < 40) begin tick(); n++; end
        chk("t4_pass1_cnt", led1[7:4], 1);
        c_addr[0] = -1; c_addr[1] = -1;

        // lock loss mid-READ
        reset_dut();
        locked = 1;
        n = 0;
        while (!(re0 && addr0 == 7) && n < 80) begin tick(); n++; end
        chk("t5_reach_read7", re0 && addr0 == 7, 1);
        locked = 0;
        tick();
        chk("t5_re_off", re0, 0);
        chk("t5_idle", led0[1:0], 0);
        chk("t5_no_report", led0[7:2], 0);
        repeat (3) tick();
        locked = 1;
        n = 0;
        while (!we0 && n < 40) begin tick(); n++; end
        chk("t5_relock_edge", n, 17);
        chk("t5_restart_addr", addr0, 0);
        chk("t5_same_seed", wdata0, 8'h00);

        // reset mid-WRITE, then 17 passes wrap pass_cnt
        reset_dut();
        locked = 1;
        n = 0;
        while (!(we0 && addr0 == 5) && n < 40) begin tick(); n++; end
        rst = 1;
        tick();
        chk("t6_rst_led", led0, 8'h00);
        chk("t6_rst_we", we0, 0);
        rst = 0;
        n = 0;
        while (!we0 && n < 40) begin tick(); n++; end
        chk("t6_seed0", wdata0, 8'h00);
        repeat (17 * 34) tick();
        chk("t6_wrap_cnt", led0[7:4], 4'h1);
        chk("t6_seed17", wdata0, 8'h11);

        // random lock drops, resets and read corruption
        reset_dut();
        locked = 1;
        rnd_bad = 1;
        dn = 0;
        for (int t = 0; t < 3000; t++) begin
            if (dn > 0) begin
                dn--;
                if (dn == 0) locked = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                locked = 0;
                dn = $urandom_range(1, 20);
            end
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
